// File: rtl/eth_tx_arbiter.sv
// Fixed-priority frame arbiter sharing one 32-bit TX stream between ARP (0), ICMP (1) and UDP (2).
// Whole frames are granted, beats pass through combinationally, and a stall watchdog aborts dead frames.
module eth_tx_arbiter #(
    parameter int IFG_CYCLES = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [95:0] i_req_data,
    input  logic [2:0]  i_req_sop,
    input  logic [2:0]  i_req_eop,
    input  logic [2:0]  i_req_vld,
    output logic [2:0]  o_req_rdy,
    output logic [31:0] o_tx_data,
    output logic        o_tx_sop,
    output logic        o_tx_eop,
    output logic        o_tx_vld,
    output logic        o_tx_err,
    input  logic        i_tx_rdy,
    output logic [2:0]  o_grant,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_abort_cnt,
    output logic [7:0]  o_stray_cnt
);

    localparam int DATA_W = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_XFER  = 3'd1;
    localparam logic [2:0] S_ABORT = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        state;
    logic [1:0]        gidx;
    logic [15:0]       wd;
    logic [15:0]       gap;

    logic [DATA_W-1:0] src_data;
    logic              src_sop;
    logic              src_eop;
    logic              src_vld;

    logic [2:0]        req_start;
    logic [2:0]        stray;
    logic              win_any;
    logic [1:0]        win_idx;
    logic [2:0]        win_onehot;

    logic [16:0]       wd_inc;
    logic              wd_hit;
    logic [2:0]        end_state;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Granted-source view; only meaningful while a source owns the stream.
    always_comb begin
        src_data = '0;
        src_sop  = 1'b0;
        src_eop  = 1'b0;
        src_vld  = 1'b0;
        case (gidx)
            2'd0: begin
                src_data = i_req_data[31:0];
                src_sop  = i_req_sop[0];
                src_eop  = i_req_eop[0];
                src_vld  = i_req_vld[0];
            end
            2'd1: begin
                src_data = i_req_data[63:32];
                src_sop  = i_req_sop[1];
                src_eop  = i_req_eop[1];
                src_vld  = i_req_vld[1];
            end
            2'd2: begin
                src_data = i_req_data[95:64];
                src_sop  = i_req_sop[2];
                src_eop  = i_req_eop[2];
                src_vld  = i_req_vld[2];
            end
            default: begin
                src_data = '0;
                src_sop  = 1'b0;
                src_eop  = 1'b0;
                src_vld  = 1'b0;
            end
        endcase
    end

    assign req_start = i_req_vld & i_req_sop;
    assign stray     = i_req_vld & ~i_req_sop;

    // Lowest index with a pending sop wins; no fairness by design.
    always_comb begin
        win_any    = |req_start;
        win_idx    = 2'd0;
        win_onehot = 3'b000;
        if (req_start[0]) begin
            win_idx    = 2'd0;
            win_onehot = 3'b001;
        end else if (req_start[1]) begin
            win_idx    = 2'd1;
            win_onehot = 3'b010;
        end else if (req_start[2]) begin
            win_idx    = 2'd2;
            win_onehot = 3'b100;
        end
    end

    assign wd_inc    = {1'b0, wd} + 17'd1;
    assign wd_hit    = (wd_inc == 17'(TIMEOUT));
    assign end_state = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
    assign o_busy    = (state != S_IDLE);

    always_comb begin
        o_req_rdy = 3'b000;
        o_tx_data = '0;
        o_tx_sop  = 1'b0;
        o_tx_eop  = 1'b0;
        o_tx_vld  = 1'b0;
        o_tx_err  = 1'b0;
        case (state)
            S_IDLE: begin
                // The winner's sop beat is held (not stray), everything else non-sop is drained.
                o_req_rdy = stray;
            end
            S_XFER: begin
                o_req_rdy = o_grant & {3{i_tx_rdy}};
                o_tx_data = src_data;
                o_tx_sop  = src_sop;
                o_tx_eop  = src_eop;
                o_tx_vld  = src_vld;
            end
            S_ABORT: begin
                o_tx_vld = 1'b1;
                o_tx_eop = 1'b1;
                o_tx_err = 1'b1;
            end
            S_FLUSH: begin
                o_req_rdy = o_grant;
            end
            default: begin
                o_req_rdy = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            o_grant     <= 3'b000;
            gidx        <= 2'd0;
            wd          <= '0;
            gap         <= '0;
            o_frame_cnt <= '0;
            o_abort_cnt <= '0;
            o_stray_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|stray) begin
                        o_stray_cnt <= sat_inc8(o_stray_cnt);
                    end
                    if (win_any) begin
                        o_grant <= win_onehot;
                        gidx    <= win_idx;
                        wd      <= '0;
                        state   <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (src_vld && i_tx_rdy) begin
                        wd <= '0;
                        if (src_eop) begin
                            o_frame_cnt <= o_frame_cnt + 16'd1;
                            o_grant     <= 3'b000;
                            gap         <= '0;
                            state       <= end_state;
                        end
                    end else if (!src_vld) begin
                        // Only a silent source counts toward abort; backpressure just holds.
                        wd <= wd_inc[15:0];
                        if (wd_hit) begin
                            state <= S_ABORT;
                        end
                    end
                end
                S_ABORT: begin
                    if (i_tx_rdy) begin
                        o_abort_cnt <= sat_inc8(o_abort_cnt);
                        wd          <= '0;
                        state       <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (src_vld) begin
                        wd <= '0;
                        if (src_eop) begin
                            o_grant <= 3'b000;
                            gap     <= '0;
                            state   <= end_state;
                        end
                    end else begin
                        wd <= wd_inc[15:0];
                        if (wd_hit) begin
                            o_grant <= 3'b000;
                            gap     <= '0;
                            state   <= end_state;
                        end
                    end
                end
                S_GAP: begin
                    if (gap == 16'(IFG_CYCLES - 1)) begin
                        gap   <= '0;
                        state <= S_IDLE;
                    end else begin
                        gap <= gap + 16'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    o_grant <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: per-source frame generators, a TX monitor queue and
// hand-derived expectations for ordering, latency, gap, backpressure, abort/flush, strays and reset.
module tb_eth_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] req_data;
    logic [2:0]  req_sop;
    logic [2:0]  req_eop;
    logic [2:0]  req_vld;
    logic [2:0]  req_rdy;
    logic [31:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_vld;
    logic        tx_err;
    logic        tx_rdy;
    logic [2:0]  grant;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  abort_cnt;
    logic [7:0]  stray_cnt;

    always #5 clk = ~clk;

    eth_tx_arbiter #(
        .IFG_CYCLES(3),
        .TIMEOUT   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_data (req_data),
        .i_req_sop  (req_sop),
        .i_req_eop  (req_eop),
        .i_req_vld  (req_vld),
        .o_req_rdy  (req_rdy),
        .o_tx_data  (tx_data),
        .o_tx_sop   (tx_sop),
        .o_tx_eop   (tx_eop),
        .o_tx_vld   (tx_vld),
        .o_tx_err   (tx_err),
        .i_tx_rdy   (tx_rdy),
        .o_grant    (grant),
        .o_busy     (busy),
        .o_frame_cnt(frame_cnt),
        .o_abort_cnt(abort_cnt),
        .o_stray_cnt(stray_cnt)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic [2:0]  fired  = 3'b000;
    logic [34:0] txq[$];
    int          txcyc[$];
    logic [2:0]  txgnt[$];

    int src_len[3];
    int src_pos[3];
    int stall_at[3];
    int stall_len[3];
    int strays[3];
    int fid[3];
    int first_pres[3];
    bit act[3];

    always @(posedge clk) cyc <= cyc + 1;

    // TX monitor and source handshake sampling, away from the active edge.
    always @(negedge clk) begin
        fired <= req_vld & req_rdy;
        if (tx_vld && tx_rdy) begin
            txq.push_back({tx_err, tx_sop, tx_eop, tx_data});
            txcyc.push_back(cyc);
            txgnt.push_back(grant);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] beat_data(input int k, input int f, input int p);
        logic [31:0] r;
        r = {k[3:0], f[11:0], p[15:0]};
        return r;
    endfunction

    function automatic logic [34:0] exp_beat(input int k, input int f, input int p, input int len);
        logic s;
        logic e;
        s = (p == 0);
        e = (p == len - 1);
        return {1'b0, s, e, beat_data(k, f, p)};
    endfunction

    task automatic drive();
        logic [95:0] d;
        logic [2:0]  s;
        logic [2:0]  e;
        logic [2:0]  v;
        d = '0;
        s = '0;
        e = '0;
        v = '0;
        for (int k = 0; k < 3; k++) begin
            if (fired[k]) begin
                if (strays[k] > 0) strays[k]--;
                else if (act[k]) begin
                    src_pos[k]++;
                    if (src_pos[k] == src_len[k]) act[k] = 1'b0;
                end
            end
            if (strays[k] > 0) begin
                v[k] = 1'b1;
                d[32*k +: 32] = beat_data(k, fid[k], 65535);
            end else if (act[k]) begin
                if (src_pos[k] == stall_at[k] && stall_len[k] > 0) begin
                    stall_len[k]--;
                end else begin
                    v[k] = 1'b1;
                    s[k] = (src_pos[k] == 0);
                    e[k] = (src_pos[k] == src_len[k] - 1);
                    d[32*k +: 32] = beat_data(k, fid[k], src_pos[k]);
                    if (s[k] && first_pres[k] < 0) first_pres[k] = cyc;
                end
            end
        end
        req_data = d;
        req_sop  = s;
        req_eop  = e;
        req_vld  = v;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic start_frame(input int k, input int len, input int sat, input int sln);
        fid[k]++;
        act[k]        = 1'b1;
        src_pos[k]    = 0;
        src_len[k]    = len;
        stall_at[k]   = sat;
        stall_len[k]  = sln;
        first_pres[k] = -1;
    endtask

    task automatic clear_mon();
        txq.delete();
        txcyc.delete();
        txgnt.delete();
    endtask

    task automatic check_frame(input string tag, input int base, input int k, input int f,
                               input int len, input int n);
        for (int i = 0; i < n; i++) begin
            if (base + i < txq.size()) check(tag, txq[base + i], exp_beat(k, f, i, len));
            else check({tag, "_missing"}, 0, 1);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && busy; i++) tick();
        check(tag, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int f0;
        int fu;
        int s0;
        rst      = 1'b1;
        req_data = '0;
        req_sop  = '0;
        req_eop  = '0;
        req_vld  = '0;
        tx_rdy   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            act[k] = 1'b0; src_pos[k] = 0; src_len[k] = 0; stall_at[k] = 99;
            stall_len[k] = 0; strays[k] = 0; fid[k] = 0; first_pres[k] = -1;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tx", {tx_vld, tx_sop, tx_eop, tx_err, tx_data}, 0);
        check("rst_rdy", req_rdy, 0);
        check("rst_cnts", {frame_cnt, abort_cnt, stray_cnt}, 0);

        // Single ARP frame
        clear_mon();
        start_frame(0, 11, 99, 0);
        f0 = fid[0];
        for (int i = 0; i < 100 && frame_cnt != 16'd1; i++) tick();
        check("arp_frame_cnt", frame_cnt, 1);
        check("arp_beats", txq.size(), 11);
        check_frame("arp_beat", 0, 0, f0, 11, 11);
        if (txcyc.size() >= 11) begin
            check("arp_latency", txcyc[0] - first_pres[0], 1);
            check("arp_contig", txcyc[10] - txcyc[0], 10);
            check("arp_grant", txgnt[5], 3'b001);
        end else check("arp_short", txcyc.size(), 11);
        wait_idle("arp_idle");

        // ARP and UDP collide
        clear_mon();
        start_frame(0, 11, 99, 0);
        start_frame(2, 43, 99, 0);
        f0 = fid[0];
        fu = fid[2];
        for (int i = 0; i < 200 && frame_cnt != 16'd3; i++) tick();
        check("pri_frame_cnt", frame_cnt, 3);
        check("pri_beats", txq.size(), 54);
        check_frame("pri_arp", 0, 0, f0, 11, 11);
        check_frame("pri_udp", 11, 2, fu, 43, 43);
        if (txcyc.size() >= 12) begin
            check("pri_gap", txcyc[11] - txcyc[10], 5);
            check("pri_grant_arp", txgnt[0], 3'b001);
            check("pri_grant_udp", txgnt[11], 3'b100);
        end else check("pri_short", txcyc.size(), 54);
        wait_idle("pri_idle");

        // ICMP under long downstream backpressure
        clear_mon();
        start_frame(1, 25, 99, 0);
        f0 = fid[1];
        for (int i = 0; i < 50 && txq.size() < 10; i++) tick();
        tx_rdy = 1'b0;
        repeat (30) tick();
        check("bp_busy", busy, 1);
        check("bp_grant", grant, 3'b010);
        check("bp_held", tx_vld, 1);
        check("bp_abort_mid", abort_cnt, 0);
        tx_rdy = 1'b1;
        for (int i = 0; i < 100 && frame_cnt != 16'd4; i++) tick();
        check("bp_frame_cnt", frame_cnt, 4);
        check("bp_beats", txq.size(), 25);
        check_frame("bp_beat", 0, 1, f0, 25, 25);
        check("bp_abort", abort_cnt, 0);
        wait_idle("bp_idle");

        // UDP stalls 20 cycles: abort, flush times out too, tail drains as strays
        clear_mon();
        s0 = stray_cnt;
        start_frame(2, 12, 5, 20);
        fu = fid[2];
        for (int i = 0; i < 200 && (act[2] || busy); i++) tick();
        check("ab1_beats", txq.size(), 6);
        check_frame("ab1_beat", 0, 2, fu, 12, 5);
        if (txq.size() >= 6) check("ab1_err_beat", txq[5], {1'b1, 1'b0, 1'b1, 32'h0});
        check("ab1_abort_cnt", abort_cnt, 1);
        check("ab1_stray", stray_cnt - s0, 7);
        check("ab1_frame_cnt", frame_cnt, 4);
        check("ab1_idle", busy, 0);

        // UDP stalls 10 cycles: tail consumed in FLUSH
        clear_mon();
        s0 = stray_cnt;
        start_frame(2, 12, 5, 10);
        fu = fid[2];
        for (int i = 0; i < 200 && (act[2] || busy); i++) tick();
        check("ab2_beats", txq.size(), 6);
        check_frame("ab2_beat", 0, 2, fu, 12, 5);
        if (txq.size() >= 6) check("ab2_err_beat", txq[5], {1'b1, 1'b0, 1'b1, 32'h0});
        check("ab2_abort_cnt", abort_cnt, 2);
        check("ab2_stray", stray_cnt - s0, 0);
        check("ab2_frame_cnt", frame_cnt, 4);

        // Strays in IDLE, then reset mid-frame
        s0 = stray_cnt;
        strays[2] = 3;
        tick();
        check("stray_rdy", req_rdy, 3'b100);
        for (int i = 0; i < 20 && strays[2] > 0; i++) tick();
        check("stray_cnt", stray_cnt - s0, 3);

        clear_mon();
        start_frame(0, 11, 99, 0);
        for (int i = 0; i < 50 && txq.size() < 4; i++) tick();
        check("prerst_busy", busy, 1);
        rst    = 1'b1;
        act[0] = 1'b0;
        tick();
        check("mrst_tx", {tx_vld, tx_sop, tx_eop, tx_err, tx_data}, 0);
        check("mrst_rdy", req_rdy, 0);
        check("mrst_grant", grant, 0);
        check("mrst_busy", busy, 0);
        check("mrst_cnts", {frame_cnt, abort_cnt, stray_cnt}, 0);
        rst = 1'b0;
        clear_mon();
        start_frame(1, 25, 99, 0);
        f0 = fid[1];
        for (int i = 0; i < 100 && frame_cnt != 16'd1; i++) tick();
        check("post_frame_cnt", frame_cnt, 1);
        check("post_beats", txq.size(), 25);
        check_frame("post_beat", 0, 1, f0, 25, 25);
        if (txcyc.size() >= 1) begin
            check("post_latency", txcyc[0] - first_pres[1], 1);
            check("post_grant", txgnt[0], 3'b010);
        end else check("post_short", txcyc.size(), 25);
        wait_idle("post_idle");

        // Stray counter saturation
        strays[2] = 300;
        for (int i = 0; i < 400 && strays[2] > 0; i++) tick();
        check("stray_sat", stray_cnt, 8'hFF);
        check("stray_sat_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
